logic_op_ctrl: RTL and testbench
================================

# logic_op_ctrl

Multi-cycle issue controller for the 16-bit logic unit in the unpipelined datapath. Accepts one register-register logic instruction at a time over a valid/ready handshake and reads both source registers from the register file. It then drives operands and the 2-bit operation select into the logic unit, captures the result and writes it back. It also maintains a zero flag and reports illegal opcodes.

## Interface
- No parameters; data width fixed at 16, register address width fixed at 4.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept (high only in IDLE)
- instr  in  16  [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt
- rf_rd_addr1 / rf_rd_addr2  out  4  register file read addresses (rs / rt)
- rf_rd_data1 / rf_rd_data2  in  16  register file read data, synchronous read (valid one cycle after address)
- lu_a / lu_b  out  16  logic unit operands
- lu_op  out  2  logic unit select: 01 OR, 10 XOR, 11 AND, 00 forces logic unit output to 0
- lu_out  in  16  logic unit result (combinational)
- rf_we  out  1  register write enable, one-cycle pulse
- rf_wr_addr  out  4  write address
- rf_wr_data  out  16  write data
- done  out  1  one-cycle pulse per retired instruction (legal or illegal)
- illegal  out  1  one-cycle pulse, coincident with done, for unsupported opcode
- z_flag  out  1  registered: 1 when last written result was 0x0000

## Operation
- Opcode decode: 4'h4 -> lu_op 01 (OR), 4'h5 -> 10 (XOR), 4'h6 -> 11 (AND); every other opcode illegal.
- FSM states: IDLE, READ, EXEC, WB.
- IDLE: instr_ready=1. On instr_valid&&instr_ready: latch opcode/rd/decoded op, load rf_rd_addr1<=rs, rf_rd_addr2<=rt. Legal -> READ; illegal -> WB.
- READ: rf_rd_data1/2 valid; latch into a_q/b_q at end of cycle -> EXEC.
- EXEC: lu_a=a_q, lu_b=b_q, lu_op=op_q; latch lu_out into res_q at end of cycle -> WB.
- WB: done=1; rf_wr_addr=rd, rf_wr_data=res_q; rf_we=1 only if legal and rd!=0 (r0 hardwired zero, write suppressed); z_flag<=(res_q==0) whenever legal (including rd==0). Illegal: illegal=1, rf_we=0, z_flag unchanged. -> IDLE.
- lu_op = 00 and lu_a/lu_b = 0 in every state except EXEC.
- rf_rd_addr1/2 hold last loaded values outside accept.
- instr ignored when instr_ready=0; no buffering, no back-pressure beyond instr_ready.
- rs==rt and rs==rd permitted; read occurs before write, no hazard (one instruction in flight).

## Timing
- Reset (async assert, sync release): state IDLE; instr_ready=1 (follows state), rf_rd_addr1/2=0, lu_a/lu_b=0, lu_op=00, rf_we=0, rf_wr_addr=0, rf_wr_data=0, done=0, illegal=0, z_flag=0, internal latches cleared.
- Reset mid-operation: in-flight instruction dropped, no write, no done.
- Legal latency: accept at edge k; READ cycle k+1, EXEC k+2, WB (done, rf_we) k+3; instr_ready high again cycle k+4. Throughput 1 instruction / 4 cycles.
- Illegal latency: accept at edge k, WB (done, illegal) cycle k+1, instr_ready high k+2.
- instr_valid held high continuously: next accept on first IDLE cycle after WB, no gap beyond that.
- All outputs registered or decoded purely from state and internal registers; no combinational path from instr/rf_rd_data/lu_out to any output.

## Test plan
- Reset: assert rst_n=0 mid-EXEC -> immediate IDLE, rf_we=0, done=0, z_flag=0, lu_op=00; release -> instr_ready=1 next cycle.
- OR/XOR/AND: r1=0x00FF, r2=0x0F0F; issue 0x4312, 0x5412, 0x6512 back-to-back with instr_valid held -> writes r3=0x0FFF, r4=0x0FF0, r5=0x000F, each done 3 cycles after accept, accepts spaced 4 cycles, lu_op 01/10/11 only in EXEC.
- Zero flag: r1=0xAAAA, r2=0x5555; 0x6612 -> r6=0x0000, z_flag=1; then 0x4712 -> r7=0xFFFF, z_flag=0.
- r0 suppression: 0x5011 with r1=0x1234 -> done pulses, rf_we stays 0, z_flag=1 (result 0).
- Illegal: instr=0xA123 -> done and illegal high together one cycle after accept, rf_we=0, z_flag unchanged, lu_op stays 00.
- Handshake: instr_valid toggled during READ/EXEC/WB with other values -> ignored; only the IDLE-cycle instruction executes.

Source files
------------

// File: rtl/logic_op_ctrl.sv
// Multi-cycle issue controller for the 16-bit logic unit: accepts one logic
// instruction, reads both sources, executes through the logic unit and writes back.
module logic_op_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [3:0]  rf_rd_addr1,
    output logic [3:0]  rf_rd_addr2,
    input  logic [15:0] rf_rd_data1,
    input  logic [15:0] rf_rd_data2,
    output logic [15:0] lu_a,
    output logic [15:0] lu_b,
    output logic [1:0]  lu_op,
    input  logic [15:0] lu_out,
    output logic        rf_we,
    output logic [3:0]  rf_wr_addr,
    output logic [15:0] rf_wr_data,
    output logic        done,
    output logic        illegal,
    output logic        z_flag
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} stateT;

    stateT       state;
    logic [3:0]  rdQ;
    logic [1:0]  opQ;
    logic        legalQ;
    logic [15:0] aQ;
    logic [15:0] bQ;
    logic [15:0] resQ;
    logic [1:0]  decOp;
    logic        decLegal;

    // A select of 00 doubles as "not a logic op", so a zero decode marks the opcode illegal.
    always_comb begin
        decOp = 2'b00;
        case (instr[15:12])
            4'h4:    decOp = 2'b01;
            4'h5:    decOp = 2'b10;
            4'h6:    decOp = 2'b11;
            default: decOp = 2'b00;
        endcase
        decLegal = (decOp != 2'b00);
    end

    assign instr_ready = (state == IDLE);
    assign lu_a        = (state == EXEC) ? aQ  : 16'h0000;
    assign lu_b        = (state == EXEC) ? bQ  : 16'h0000;
    assign lu_op       = (state == EXEC) ? opQ : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rdQ         <= 4'h0;
            opQ         <= 2'b00;
            legalQ      <= 1'b0;
            aQ          <= 16'h0000;
            bQ          <= 16'h0000;
            resQ        <= 16'h0000;
            rf_rd_addr1 <= 4'h0;
            rf_rd_addr2 <= 4'h0;
            rf_we       <= 1'b0;
            rf_wr_addr  <= 4'h0;
            rf_wr_data  <= 16'h0000;
            done        <= 1'b0;
            illegal     <= 1'b0;
            z_flag      <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            rf_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        rdQ         <= instr[11:8];
                        opQ         <= decOp;
                        legalQ      <= decLegal;
                        resQ        <= 16'h0000;
                        rf_rd_addr1 <= instr[7:4];
                        rf_rd_addr2 <= instr[3:0];
                        // Illegal opcodes skip straight to write-back to retire quickly.
                        if (decLegal) begin
                            state <= READ;
                        end else begin
                            state      <= WB;
                            done       <= 1'b1;
                            illegal    <= 1'b1;
                            rf_wr_addr <= instr[11:8];
                            rf_wr_data <= 16'h0000;
                        end
                    end
                end
                READ: begin
                    aQ    <= rf_rd_data1;
                    bQ    <= rf_rd_data2;
                    state <= EXEC;
                end
                EXEC: begin
                    resQ       <= lu_out;
                    done       <= 1'b1;
                    rf_we      <= (rdQ != 4'h0);
                    rf_wr_addr <= rdQ;
                    rf_wr_data <= lu_out;
                    state      <= WB;
                end
                WB: begin
                    // r0 writes are suppressed but still update the flag.
                    if (legalQ) begin
                        z_flag <= (resQ == 16'h0000);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_op_ctrl.sv
// Directed self-checking bench for logic_op_ctrl with a register file and logic unit model.
module tb_logic_op_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  rf_rd_addr1;
    logic [3:0]  rf_rd_addr2;
    logic [15:0] rf_rd_data1;
    logic [15:0] rf_rd_data2;
    logic [15:0] lu_a;
    logic [15:0] lu_b;
    logic [1:0]  lu_op;
    logic [15:0] lu_out;
    logic        rf_we;
    logic [3:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic        done;
    logic        illegal;
    logic        z_flag;

    logic [15:0] regs [16] = '{default: 16'h0000};
    logic        tbWe;
    logic [3:0]  tbAddr;
    logic [15:0] tbData;

    int checkCount = 0;
    int errorCount = 0;

    logic_op_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_rd_addr1 (rf_rd_addr1),
        .rf_rd_addr2 (rf_rd_addr2),
        .rf_rd_data1 (rf_rd_data1),
        .rf_rd_data2 (rf_rd_data2),
        .lu_a        (lu_a),
        .lu_b        (lu_b),
        .lu_op       (lu_op),
        .lu_out      (lu_out),
        .rf_we       (rf_we),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data),
        .done        (done),
        .illegal     (illegal),
        .z_flag      (z_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller's address register serves as the RF read-address register.
    assign rf_rd_data1 = regs[rf_rd_addr1];
    assign rf_rd_data2 = regs[rf_rd_addr2];

    always_comb begin
        lu_out = 16'h0000;
        case (lu_op)
            2'b01:   lu_out = lu_a | lu_b;
            2'b10:   lu_out = lu_a ^ lu_b;
            2'b11:   lu_out = lu_a & lu_b;
            default: lu_out = 16'h0000;
        endcase
    end

    always @(posedge clk) begin
        if (rf_we)
            regs[rf_wr_addr] <= rf_wr_data;
        else if (tbWe)
            regs[tbAddr] <= tbData;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic loadReg(input logic [3:0] addr, input logic [15:0] data);
        @(negedge clk);
        tbWe   = 1'b1;
        tbAddr = addr;
        tbData = data;
        @(negedge clk);
        tbWe   = 1'b0;
    endtask

    // Issues one legal instruction from IDLE and checks every phase; noise wiggles the inputs while busy.
    task automatic applyStimulus(input logic [15:0] ins, input logic [1:0] expOp,
                                 input logic [15:0] expA, input logic [15:0] expB,
                                 input logic [15:0] expRes, input logic expWe,
                                 input logic expZ, input logic hold, input logic noise);
        instr_valid = 1'b1;
        instr       = ins;
        checkOutput("idleReady", instr_ready, 1);
        @(posedge clk); #1;
        checkOutput("readReady", instr_ready, 0);
        checkOutput("readOp", lu_op, 0);
        checkOutput("readAddr1", rf_rd_addr1, ins[7:4]);
        checkOutput("readAddr2", rf_rd_addr2, ins[3:0]);
        if (noise) begin
            instr_valid = 1'b0;
            instr       = 16'h4FFF;
        end
        @(posedge clk); #1;
        checkOutput("execOp", lu_op, expOp);
        checkOutput("execA", lu_a, expA);
        checkOutput("execB", lu_b, expB);
        checkOutput("execDone", done, 0);
        if (noise) begin
            instr_valid = 1'b1;
            instr       = 16'h6F00;
        end
        @(posedge clk); #1;
        checkOutput("wbDone", done, 1);
        checkOutput("wbIllegal", illegal, 0);
        checkOutput("wbWe", rf_we, expWe);
        checkOutput("wbAddr", rf_wr_addr, ins[11:8]);
        checkOutput("wbData", rf_wr_data, expRes);
        checkOutput("wbOp", lu_op, 0);
        if (noise) begin
            instr_valid = 1'b1;
            instr       = 16'h5EEE;
        end
        @(posedge clk); #1;
        checkOutput("postReady", instr_ready, 1);
        checkOutput("postDone", done, 0);
        checkOutput("postWe", rf_we, 0);
        checkOutput("postZ", z_flag, expZ);
        if (!hold)
            instr_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        tbWe        = 1'b0;
        tbAddr      = 4'h0;
        tbData      = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstReady", instr_ready, 1);
        checkOutput("rstDone", done, 0);
        checkOutput("rstWe", rf_we, 0);
        checkOutput("rstZ", z_flag, 0);
        checkOutput("rstOp", lu_op, 0);
        checkOutput("rstAddr1", rf_rd_addr1, 0);
        checkOutput("rstWrData", rf_wr_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] OR/XOR/AND back-to-back");
        loadReg(4'd1, 16'h00FF);
        loadReg(4'd2, 16'h0F0F);
        applyStimulus(16'h4312, 2'b01, 16'h00FF, 16'h0F0F, 16'h0FFF, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(16'h5412, 2'b10, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(16'h6512, 2'b11, 16'h00FF, 16'h0F0F, 16'h000F, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("r3", regs[3], 16'h0FFF);
        checkOutput("r4", regs[4], 16'h0FF0);
        checkOutput("r5", regs[5], 16'h000F);

        $display("[TB] zero flag");
        loadReg(4'd1, 16'hAAAA);
        loadReg(4'd2, 16'h5555);
        applyStimulus(16'h6612, 2'b11, 16'hAAAA, 16'h5555, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(16'h4712, 2'b01, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("r7", regs[7], 16'hFFFF);

        $display("[TB] r0 suppression");
        loadReg(4'd1, 16'h1234);
        applyStimulus(16'h5011, 2'b10, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("r0", regs[0], 16'h0000);

        $display("[TB] illegal opcode");
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = 16'hA123;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        checkOutput("illDone", done, 1);
        checkOutput("illFlag", illegal, 1);
        checkOutput("illWe", rf_we, 0);
        checkOutput("illOp", lu_op, 0);
        checkOutput("illReady", instr_ready, 0);
        @(posedge clk); #1;
        checkOutput("illPostReady", instr_ready, 1);
        checkOutput("illPostDone", done, 0);
        checkOutput("illPostIllegal", illegal, 0);
        checkOutput("illZ", z_flag, 1);
        checkOutput("illR1", regs[1], 16'h1234);

        $display("[TB] reset during EXEC");
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = 16'h6812;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("midExecOp", lu_op, 2'b11);
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        #1;
        checkOutput("midRstReady", instr_ready, 1);
        checkOutput("midRstOp", lu_op, 0);
        checkOutput("midRstDone", done, 0);
        checkOutput("midRstWe", rf_we, 0);
        checkOutput("midRstZ", z_flag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("relReady", instr_ready, 1);
        @(posedge clk); #1;
        checkOutput("relDone", done, 0);
        checkOutput("r8", regs[8], 16'h0000);

        $display("[TB] handshake noise");
        @(negedge clk);
        applyStimulus(16'h4312, 2'b01, 16'h1234, 16'h5555, 16'h5775, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        checkOutput("noiseIdle", instr_ready, 1);
        checkOutput("noiseDone", done, 0);
        checkOutput("noiseR3", regs[3], 16'h5775);
        checkOutput("noiseR14", regs[14], 16'h0000);
        checkOutput("noiseR15", regs[15], 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
